button_debouncer_fabric: RTL

Fabric-side input conditioner for a BeagleV-Fire user push-button; it is the input counterpart to the fabric LED output path. It synchronises the raw asynchronous pin into the 50 MHz FIC clock domain and rejects contact bounce. It then produces a clean level plus single-cycle press, release and long-press event pulses for downstream fabric logic such as LED mode control.

---
 rtl/button_debouncer_fabric.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/button_debouncer_fabric.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, and registered
// level / press / release / long-press outputs in the fabric clock domain.
module button_debouncer_fabric #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int DB_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LP_CYCLES = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
  localparam int DB_W      = $clog2(DB_CYCLES) + 1;
  localparam int LP_W      = $clog2(LP_CYCLES) + 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LP_CYCLES);

  generate
    if (DB_CYCLES < 2 || LP_CYCLES <= DB_CYCLES) begin : g_bad_params
      $error("button_debouncer_fabric: need DB_CYCLES >= 2 and LP_CYCLES > DB_CYCLES");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  // Synchroniser idles at the pin's released level so reset never looks like a press.
  logic r_sync1, r_sync2;
  logic w_s;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ ACTIVE_LOW;

  state_t            r_state, w_state_nxt;
  logic [DB_W-1:0]   r_db_cnt, w_db_nxt;
  logic [LP_W-1:0]   r_lp_cnt, w_lp_nxt;
  logic              r_level, w_level_nxt;
  logic              r_press, w_press_nxt;
  logic              r_rel, w_rel_nxt;
  logic              r_long, w_long_nxt;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_db_cnt <= '0;
      r_lp_cnt <= '0;
      r_level  <= 1'b0;
      r_press  <= 1'b0;
      r_rel    <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_nxt;
      r_lp_cnt <= w_lp_nxt;
      r_level  <= w_level_nxt;
      r_press  <= w_press_nxt;
      r_rel    <= w_rel_nxt;
      r_long   <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_db_nxt    = r_db_cnt;
    w_lp_nxt    = r_lp_cnt;
    w_level_nxt = r_level;
    w_press_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_CHK;
          w_db_nxt    = '0;
        end
      end
      PRESS_CHK: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = PRESSED;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_lp_nxt    = '0;
        end else begin
          w_db_nxt = r_db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        // Saturating hold counter: the LP_LAST->LP_SAT step fires the pulse exactly once.
        if (r_lp_cnt != LP_SAT) w_lp_nxt = r_lp_cnt + 1'b1;
        if (r_lp_cnt == LP_LAST) w_long_nxt = 1'b1;
        if (!w_s) begin
          w_state_nxt = REL_CHK;
          w_db_nxt    = '0;
        end
      end
      REL_CHK: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_level_nxt = 1'b0;
          w_rel_nxt   = 1'b1;
        end else begin
          w_db_nxt = r_db_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign btn_level        = r_level;
  assign press_pulse      = r_press;
  assign release_pulse    = r_rel;
  assign long_press_pulse = r_long;

endmodule
